// File: rtl/sigma_delta_decimator.sv
// Third-order CIC decimator turning a 1-bit delta-sigma stream into signed PCM.
// Integrators run every accepted bit; capture and comb stages run once per frame.
module sigma_delta_decimator #(
  parameter int BW     = 16,
  parameter int LOG2_R = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_i,
  input  logic                     bit_valid_i,
  output logic signed [BW-1:0]     pcm_o,
  output logic                     pcm_valid_o,
  output logic [LOG2_R-1:0]        phase_o
);

  localparam int W     = 2 + 3 * LOG2_R;
  localparam int SHIFT = 3 * LOG2_R - (BW - 1);

  localparam logic signed [W-1:0] PMAX =
    {{(W-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [W-1:0] NMIN = ~PMAX;

  logic signed [W-1:0] x;
  logic signed [W-1:0] i1_q, i1_d;
  logic signed [W-1:0] i2_q, i2_d;
  logic signed [W-1:0] i3_q, i3_d;
  logic signed [W-1:0] d_q, d_d;
  logic signed [W-1:0] dp_q, dp_d;
  logic signed [W-1:0] c1p_q, c1p_d;
  logic signed [W-1:0] c2p_q, c2p_d;
  logic signed [W-1:0] c1, c2, c3, sh;
  logic [LOG2_R-1:0]   cnt_q, cnt_d;
  logic                cap_q, cap_d;
  logic                comb_q, comb_d;
  logic signed [BW-1:0] pcm_q, pcm_d;
  logic                vld_q, vld_d;

  // bit 1 -> +1, bit 0 -> -1 (all ones)
  assign x = {{(W-1){~bit_i}}, 1'b1};

  always_comb begin
    i1_d   = i1_q;
    i2_d   = i2_q;
    i3_d   = i3_q;
    cnt_d  = cnt_q;
    cap_d  = 1'b0;
    if (bit_valid_i) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + 1'b1;
      cap_d = (cnt_q == '1);
    end
  end

  always_comb begin
    comb_d = cap_q;
    d_d    = cap_q ? i3_q : d_q;
    c1     = d_q - dp_q;
    c2     = c1 - c1p_q;
    c3     = c2 - c2p_q;
    sh     = c3 >>> SHIFT;
    dp_d   = dp_q;
    c1p_d  = c1p_q;
    c2p_d  = c2p_q;
    pcm_d  = pcm_q;
    vld_d  = 1'b0;
    if (comb_q) begin
      dp_d  = d_q;
      c1p_d = c1;
      c2p_d = c2;
      vld_d = 1'b1;
      if (sh > PMAX)
        pcm_d = PMAX[BW-1:0];
      else if (sh < NMIN)
        pcm_d = NMIN[BW-1:0];
      else
        pcm_d = sh[BW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      d_q    <= '0;
      dp_q   <= '0;
      c1p_q  <= '0;
      c2p_q  <= '0;
      cnt_q  <= '0;
      cap_q  <= 1'b0;
      comb_q <= 1'b0;
      pcm_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      i3_q   <= i3_d;
      d_q    <= d_d;
      dp_q   <= dp_d;
      c1p_q  <= c1p_d;
      c2p_q  <= c2p_d;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
      comb_q <= comb_d;
      pcm_q  <= pcm_d;
      vld_q  <= vld_d;
    end
  end

  assign pcm_o       = pcm_q;
  assign pcm_valid_o = vld_q;
  assign phase_o     = cnt_q;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Scoreboard bench for sigma_delta_decimator: expected samples queued per frame,
// checked for value and latency when pcm_valid_o fires.
module tb_sigma_delta_decimator;

  localparam int BW     = 16;
  localparam int LOG2_R = 6;
  localparam int R      = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 bit_i = 1'b0;
  logic                 bit_valid_i = 1'b0;
  logic signed [BW-1:0] pcm_o;
  logic                 pcm_valid_o;
  logic [LOG2_R-1:0]    phase_o;

  sigma_delta_decimator #(.BW(BW), .LOG2_R(LOG2_R)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .pcm_o       (pcm_o),
    .pcm_valid_o (pcm_valid_o),
    .phase_o     (phase_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit chk;
    int val;
    int tol;
    int due;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int frames = 0;
  int exp_val = 0;
  int exp_tol = 0;

  // Called at a negedge; the next posedge accepts the bit, output due 2 edges later.
  task automatic drive(input logic b, input logic v);
    bit_i = b;
    bit_valid_i = v;
    if (v) begin
      acc_cnt++;
      if (acc_cnt % R == 0) begin
        frames++;
        sbq.push_back('{chk: (frames >= 4), val: exp_val,
                        tol: exp_tol, due: cyc + 3});
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bit_valid_i = 1'b0;
    bit_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc_cnt = 0;
    frames = 0;
    sbq.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (pcm_o !== '0) begin
      fails++;
      $display("FAIL reset_pcm got=%0d want=0", pcm_o);
    end
    tests++;
    if (pcm_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got=%b want=0", pcm_valid_o);
    end
    tests++;
    if (phase_o !== '0) begin
      fails++;
      $display("FAIL reset_phase got=%0d want=0", phase_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream(input string name, input logic [3:0] pat,
                             input int expv, input bit stall);
    exp_t e;
    int got;
    logic v;
    do_reset();
    exp_val = expv;
    exp_tol = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (stall) begin
        tests++;
        if (int'(phase_o) != acc_cnt % R) begin
          fails++;
          $display("FAIL %s phase got=%0d want=%0d",
                   name, phase_o, acc_cnt % R);
        end
      end
      if (pcm_valid_o) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL %s spurious_valid cyc=%0d", name, cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.due) begin
            fails++;
            $display("FAIL %s latency got_cyc=%0d want_cyc=%0d",
                     name, cyc, e.due);
          end
          if (e.chk) begin
            tests++;
            got = pcm_o;
            if (got > e.val + e.tol || got < e.val - e.tol) begin
              fails++;
              $display("FAIL %s pcm got=%0d want=%0d", name, got, e.val);
            end
          end
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        tests++;
        fails++;
        $display("FAIL %s missing_valid cyc=%0d want_cyc=%0d",
                 name, cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (frames >= 8 && sbq.size() == 0) begin
        drive(1'b0, 1'b0);
        break;
      end
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (frames >= 8) v = 1'b0;
      drive(pat[acc_cnt % 4], v);
    end
    if (frames < 8 || sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout frames=%0d want=8", name, frames);
      drive(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    int got;
    logic [3:0] pat;
    pat = 4'b0111;
    do_reset();
    exp_val = 16384;
    exp_tol = 0;
    for (int k = 0; k < 5 * R + 37; k++) begin
      @(negedge clk);
      if (pcm_valid_o) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL midrst spurious_valid cyc=%0d", cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.due) begin
            fails++;
            $display("FAIL midrst latency got_cyc=%0d want_cyc=%0d",
                     cyc, e.due);
          end
          if (e.chk) begin
            tests++;
            got = pcm_o;
            if (got != e.val) begin
              fails++;
              $display("FAIL midrst pcm got=%0d want=%0d", got, e.val);
            end
          end
        end
      end
      drive(pat[acc_cnt % 4], 1'b1);
    end
    @(negedge clk);
    tests++;
    if (phase_o !== 6'd37) begin
      fails++;
      $display("FAIL midrst phase_before got=%0d want=37", phase_o);
    end
    rst_n = 1'b0;
    bit_i = 1'b1;
    bit_valid_i = 1'b1;
    @(negedge clk);
    tests++;
    if (pcm_o !== '0) begin
      fails++;
      $display("FAIL midrst pcm_after got=%0d want=0", pcm_o);
    end
    tests++;
    if (pcm_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL midrst valid_after got=%b want=0", pcm_valid_o);
    end
    tests++;
    if (phase_o !== '0) begin
      fails++;
      $display("FAIL midrst phase_after got=%0d want=0", phase_o);
    end
    rst_n = 1'b1;
    bit_valid_i = 1'b0;
    acc_cnt = 0;
    frames = 0;
    sbq.delete();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pcm_valid_o) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL midrst early_valid cyc=%0d", cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.due) begin
            fails++;
            $display("FAIL midrst fresh_latency got_cyc=%0d want_cyc=%0d",
                     cyc, e.due);
          end
        end
      end
      if (frames >= 1 && sbq.size() == 0) begin
        drive(1'b0, 1'b0);
        break;
      end
      drive(pat[acc_cnt % 4], frames < 1);
    end
    if (frames < 1 || sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL midrst fresh_timeout frames=%0d want=1", frames);
      drive(1'b0, 1'b0);
    end
  endtask

  // First-order modulator model generating the loopback bitstream.
  task automatic test_loopback(input string name, input int dc);
    exp_t e;
    int got;
    int acc_m;
    logic y;
    do_reset();
    exp_val = (dc * 32768) / 32768;
    exp_tol = 64;
    acc_m = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (pcm_valid_o) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL %s spurious_valid cyc=%0d", name, cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.due) begin
            fails++;
            $display("FAIL %s latency got_cyc=%0d want_cyc=%0d",
                     name, cyc, e.due);
          end
          if (e.chk) begin
            tests++;
            got = pcm_o;
            if (got > e.val + e.tol || got < e.val - e.tol) begin
              fails++;
              $display("FAIL %s pcm got=%0d want=%0d+-%0d",
                       name, got, e.val, e.tol);
            end
          end
        end
      end
      if (frames >= 8 && sbq.size() == 0) begin
        drive(1'b0, 1'b0);
        break;
      end
      if (frames >= 8) begin
        drive(1'b0, 1'b0);
      end else begin
        y = (acc_m >= 0);
        drive(y, 1'b1);
        acc_m += dc - (y ? 32768 : -32768);
      end
    end
    if (frames < 8 || sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout frames=%0d want=8", name, frames);
      drive(1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_stream("const_one", 4'b1111, 32767, 1'b0);
    test_stream("const_zero", 4'b0000, -32768, 1'b0);
    test_stream("alternating", 4'b0101, 0, 1'b0);
    test_stream("three_quarter", 4'b0111, 16384, 1'b0);
    test_stream("stalled", 4'b0111, 16384, 1'b1);
    test_reset_midframe();
    test_loopback("loop_pos", 16384);
    test_loopback("loop_neg", -16384);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sigma_delta_decimator.md
Name: sigma_delta_decimator

Overview:
- Receive-side counterpart of the 1-bit delta-sigma modulator.
- Converts the 1-bit bitstream back into signed BW-bit PCM using a 3rd-order CIC (sinc^3) decimator with decimation ratio R = 2^LOG2_R.
- Feeds back-end checking logic and loopback test of the DAC path.
- Emits one PCM sample plus a one-cycle valid strobe per R accepted input bits.

Parameters:
- BW, 16, PCM output width (signed two's complement).
- LOG2_R, 6, log2 of decimation ratio (R = 64 default).
- Constraint: SHIFT = 3*LOG2_R - (BW-1) >= 0.
- Derived localparam W = 2 + 3*LOG2_R, the internal CIC width (20 at defaults).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- bit_i  input  1  modulator bitstream bit
- bit_valid_i  input  1  qualifies bit_i; tie high for one bit per clock
- pcm_o  output  BW  signed decimated sample, held between updates
- pcm_valid_o  output  1  one-cycle pulse when pcm_o updates
- phase_o  output  LOG2_R  current decimation counter value (debug/sync)

Behaviour:
- Reset and clock:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n: sampled on the rising clk edge, takes effect while rst_n=0.
  - Reset clears integrators I1..I3, comb delays, decimation counter, the capture register and pipeline flags.
  - Reset values: pcm_o = 0, pcm_valid_o = 0, phase_o = 0.
  - Reset mid-frame discards the partial frame. The first frame after release starts at phase 0.
- Input mapping:
  - bit_i=1 maps to x=+1; bit_i=0 maps to x=-1, both W-bit signed.
  - This matches the modulator's feedback polarity, so loopback preserves sign.
- Integrators, on each edge with bit_valid_i=1 (old values on the right-hand side):
  - I1 <= I1 + x
  - I2 <= I2 + I1
  - I3 <= I3 + I2
  - With bit_valid_i=0, integrators and counter hold.
  - Arithmetic is modulo 2^W. Wrap-around is required and must not saturate.
- Decimation counter:
  - Increments on each accepted bit and wraps from R-1 to 0.
  - When an accepted bit arrives with counter = R-1, a capture flag is set for the next cycle.
- Capture (cycle t+1, where t is the edge that accepted the R-th bit):
  - D <= I3. I3 already includes bit t.
- Comb (cycle t+2), combinational from D, registered:
  - C1 = D - D_prev
  - C2 = C1 - C1_prev
  - C3 = C2 - C2_prev
  - Update D_prev, C1_prev, C2_prev.
- Output:
  - pcm_o <= sat_BW(C3 >>> SHIFT), where >>> is an arithmetic shift.
  - Saturation clamps to [-2^(BW-1), 2^(BW-1)-1].
  - pcm_valid_o is high for exactly one cycle, coincident with the pcm_o update.
- Latency: pcm_valid_o asserts 2 edges after the edge accepting the R-th bit of a frame. It is independent of gaps in bit_valid_i.
- Timing: bit_valid_i gaps during the capture and comb cycles do not delay or corrupt the output pipeline.
- Gain: C3 full scale is ±R^3 = ±2^(3*LOG2_R). At defaults, full scale is ±2^18, giving ±32768 after the shift. The positive extreme saturates to 32767.
- Settling: the first 3 outputs after reset are transient. Outputs from the 4th onward are exact for stationary input.
- Simultaneous events: rst_n=0 overrides valid, capture and comb activity in the same cycle.

Test Plan:
- Constant bit_i=1, bit_valid_i=1:
  - 4th and later outputs: pcm_o = 32767 (saturated).
  - pcm_valid_o period is exactly 64 cycles.
- Constant bit_i=0 -> 4th and later pcm_o = -32768 exactly, with no wrap to positive.
- Alternating 1,0 -> pcm_o = 0 from the 4th output.
- Repeating 1,1,1,0 (mean x = +0.5) -> pcm_o = 16384.
- Stalls and reset:
  - Repeating 1,1,1,0 with bit_valid_i toggled pseudo-randomly (~50% duty) -> same output values; one valid pulse per 64 accepted bits; latency 2 edges after the 64th accepted bit.
  - rst_n low for 1 cycle at phase 37 -> pcm_o = 0, pcm_valid_o = 0, phase_o = 0 next cycle; next valid pulse after 64 fresh bits.
- Loopback through the filter plus modulator path:
  - DC input 0x4000 -> settled pcm_o within 16384 ±64.
  - DC input 0xC000 -> within -16384 ±64.
